// File: rtl/morse_pkg.sv
// morse_pkg
// Shared definitions for the Morse-to-ASCII decoder:
//   - 2-bit symbol encodings used in each Morse slot
//   - ASCII constants for the inserted word gap and for undecodable letters
//   - packed 10-bit pattern type, slot 1 in bits [1:0] up to slot 5 in bits [9:8]
//   - word-gap timer state encoding
package morse_pkg;

    localparam logic [1:0] SYM_EMPTY = 2'b00;
    localparam logic [1:0] SYM_DOT   = 2'b01;
    localparam logic [1:0] SYM_DASH  = 2'b10;
    localparam logic [1:0] SYM_BAD   = 2'b11;

    localparam logic [7:0] CH_SPACE   = 8'h20;
    localparam logic [7:0] CH_UNKNOWN = 8'h3F;

    typedef logic [9:0] morse_pat_t;

    typedef enum logic {
        GAP_IDLE,
        GAP_ARMED
    } gap_state_e;

endpackage

// File: rtl/morse_to_letter_if.sv
// morse_to_letter_if
// Bundles the letter input bus from button_to_morse and the valid/ready
// character output towards the display/compare stage.
//   master : producer of letters and consumer of characters (drives slots,
//            index, letter_done, out_ready)
//   slave  : the decoder (drives out_char, out_valid, fifo_count, overflow)
interface morse_to_letter_if #(
    parameter int DEPTH = 8
);
    logic [1:0]             morse_one;
    logic [1:0]             morse_two;
    logic [1:0]             morse_three;
    logic [1:0]             morse_four;
    logic [1:0]             morse_five;
    logic [2:0]             morse_index;
    logic                   letter_done;
    logic                   out_ready;
    logic [7:0]             out_char;
    logic                   out_valid;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;

    modport master (
        output morse_one, morse_two, morse_three, morse_four, morse_five,
        output morse_index, letter_done, out_ready,
        input  out_char, out_valid, fifo_count, overflow
    );

    modport slave (
        input  morse_one, morse_two, morse_three, morse_four, morse_five,
        input  morse_index, letter_done, out_ready,
        output out_char, out_valid, fifo_count, overflow
    );

endinterface

// File: rtl/morse_lut.sv
// morse_lut
// Purely combinational Morse letter lookup.
//   pattern : five 2-bit symbol slots, slot 1 in [1:0]
//   index   : number of used slots (1..5 valid)
//   ascii   : uppercase letter or digit, '?' when undecodable
module morse_lut
    import morse_pkg::*;
(
    input  morse_pat_t  pattern,
    input  logic [2:0]  index,
    output logic [7:0]  ascii
);

    logic       bad;
    logic [4:0] code;
    logic [1:0] slot;

    // Used slots are folded into a right-aligned dot=0/dash=1 code with
    // slot 1 as MSB; the length is kept alongside so prefixes stay distinct.
    always_comb begin
        bad  = (index == 3'd0) || (index > 3'd5);
        code = '0;
        slot = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (i < 32'(index)) begin
                slot = pattern[2*i +: 2];
                if (slot == SYM_DOT) begin
                    code = {code[3:0], 1'b0};
                end else if (slot == SYM_DASH) begin
                    code = {code[3:0], 1'b1};
                end else if (slot == SYM_EMPTY || slot == SYM_BAD) begin
                    bad = 1'b1;
                end
            end
        end

        ascii = CH_UNKNOWN;
        if (!bad) begin
            case ({index, code})
                8'b001_00000: ascii = "E";
                8'b001_00001: ascii = "T";
                8'b010_00000: ascii = "I";
                8'b010_00001: ascii = "A";
                8'b010_00010: ascii = "N";
                8'b010_00011: ascii = "M";
                8'b011_00000: ascii = "S";
                8'b011_00001: ascii = "U";
                8'b011_00010: ascii = "R";
                8'b011_00011: ascii = "W";
                8'b011_00100: ascii = "D";
                8'b011_00101: ascii = "K";
                8'b011_00110: ascii = "G";
                8'b011_00111: ascii = "O";
                8'b100_00000: ascii = "H";
                8'b100_00001: ascii = "V";
                8'b100_00010: ascii = "F";
                8'b100_00100: ascii = "L";
                8'b100_00110: ascii = "P";
                8'b100_00111: ascii = "J";
                8'b100_01000: ascii = "B";
                8'b100_01001: ascii = "X";
                8'b100_01010: ascii = "C";
                8'b100_01011: ascii = "Y";
                8'b100_01100: ascii = "Z";
                8'b100_01101: ascii = "Q";
                8'b101_01111: ascii = "1";
                8'b101_00111: ascii = "2";
                8'b101_00011: ascii = "3";
                8'b101_00001: ascii = "4";
                8'b101_00000: ascii = "5";
                8'b101_10000: ascii = "6";
                8'b101_11000: ascii = "7";
                8'b101_11100: ascii = "8";
                8'b101_11110: ascii = "9";
                8'b101_11111: ascii = "0";
                default:      ascii = CH_UNKNOWN;
            endcase
        end
    end

endmodule

// File: rtl/morse_to_letter.sv
// morse_to_letter
// Captures completed Morse letters, decodes them to ASCII, inserts a space
// after an idle word gap and buffers characters in a show-ahead FIFO.
//   clock  : system clock
//   reset  : asynchronous, active-low
//   bus    : slave side of morse_to_letter_if (letter input, char output,
//            occupancy and sticky overflow)
module morse_to_letter
    import morse_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int GAP_TICKS = 7
) (
    input  logic              clock,
    input  logic              reset,
    morse_to_letter_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic             cap_valid_q, cap_valid_d;
    morse_pat_t       cap_pat_q,   cap_pat_d;
    logic [2:0]       cap_idx_q,   cap_idx_d;
    gap_state_e       gap_state_q, gap_state_d;
    logic [CW-1:0]    gap_cnt_q,   gap_cnt_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [AW:0]      count_q,     count_d;
    logic             overflow_q,  overflow_d;

    logic [7:0]       lut_char;
    logic             letter_push;
    logic             gap_expire;
    logic             space_push;
    logic             push;
    logic [7:0]       push_char;
    logic             not_empty;
    logic             full;
    logic             do_pop;
    logic             do_write;

    morse_lut u_lut (
        .pattern (cap_pat_q),
        .index   (cap_idx_q),
        .ascii   (lut_char)
    );

    always_comb begin
        cap_valid_d = 1'b0;
        cap_pat_d   = cap_pat_q;
        cap_idx_d   = cap_idx_q;
        if (bus.letter_done && bus.morse_index != 3'd0) begin
            cap_valid_d = 1'b1;
            cap_pat_d   = {bus.morse_five, bus.morse_four, bus.morse_three,
                           bus.morse_two, bus.morse_one};
            cap_idx_d   = bus.morse_index;
        end

        // Counter holds GAP_TICKS-1 in the cycle before the expiry edge, so
        // the space lands GAP_TICKS edges after the letter push. A letter
        // pending in that same cycle takes the slot and re-arms instead.
        letter_push = cap_valid_q;
        gap_expire  = (gap_state_q == GAP_ARMED) && (gap_cnt_q == GAP_LAST);
        space_push  = gap_expire && !cap_valid_q;

        gap_state_d = gap_state_q;
        gap_cnt_d   = gap_cnt_q;
        if (letter_push) begin
            gap_state_d = GAP_ARMED;
            gap_cnt_d   = '0;
        end else if (gap_expire) begin
            gap_state_d = GAP_IDLE;
            gap_cnt_d   = '0;
        end else if (gap_state_q == GAP_ARMED) begin
            gap_cnt_d   = gap_cnt_q + 1'b1;
        end

        push      = letter_push || space_push;
        push_char = letter_push ? lut_char : CH_SPACE;

        not_empty = (count_q != '0);
        full      = (count_q == FULL_CNT);
        do_pop    = not_empty && bus.out_ready;
        // When full, a simultaneous pop frees the head slot, which is exactly
        // where the write pointer sits.
        do_write  = push && (!full || do_pop);

        overflow_d = overflow_q || (push && full && !do_pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_write) begin
            mem_d[wr_ptr_q] = push_char;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        if (do_write && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_write) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cap_valid_q <= 1'b0;
            cap_pat_q   <= '0;
            cap_idx_q   <= '0;
            gap_state_q <= GAP_IDLE;
            gap_cnt_q   <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_pat_q   <= cap_pat_d;
            cap_idx_q   <= cap_idx_d;
            gap_state_q <= gap_state_d;
            gap_cnt_q   <= gap_cnt_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out_valid  = not_empty;
    assign bus.out_char   = not_empty ? mem_q[rd_ptr_q] : '0;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_morse_to_letter.sv
// tb_morse_to_letter
// Scoreboard bench: expected characters are queued as letters are driven and
// compared as the consumer side pops them.
module tb_morse_to_letter;

    localparam int DEPTH = 8;
    localparam int GAP   = 7;

    logic clock = 1'b0;
    logic reset = 1'b0;

    morse_to_letter_if #(.DEPTH(DEPTH)) bus ();

    morse_to_letter #(
        .DEPTH     (DEPTH),
        .GAP_TICKS (GAP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] exp_q [$];
    logic [7:0] exp_head;
    int last_char_cyc  = -1;
    int last_space_cyc = -1;
    int space_cnt      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Consumer-side monitor: every accepted character is checked in order.
    always @(negedge clock) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_head = exp_q.pop_front();
                check("sb_char", 32'(bus.out_char), 32'(exp_head));
            end
            if (bus.out_char == 8'h20) begin
                last_space_cyc = cyc;
                space_cnt++;
            end else begin
                last_char_cyc = cyc;
            end
        end
    end

    function automatic logic [9:0] mk(input string s);
        logic [9:0] p;
        p = '0;
        for (int i = 0; i < s.len() && i < 5; i++) begin
            if (s[i] == ".")      p[2*i +: 2] = 2'b01;
            else if (s[i] == "-") p[2*i +: 2] = 2'b10;
            else                  p[2*i +: 2] = 2'b11;
        end
        return p;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Called just after an edge; the letter is captured on the next edge.
    task automatic send(input logic [9:0] p, input logic [2:0] idx,
                        input logic [7:0] ch, input bit push, output int kcap);
        bus.morse_one   = p[1:0];
        bus.morse_two   = p[3:2];
        bus.morse_three = p[5:4];
        bus.morse_four  = p[7:6];
        bus.morse_five  = p[9:8];
        bus.morse_index = idx;
        bus.letter_done = 1'b1;
        if (push) exp_q.push_back(ch);
        kcap = cyc + 1;
        @(posedge clock);
        #1;
        bus.letter_done = 1'b0;
    endtask

    task automatic sendl(input string s, input logic [7:0] ch, input bit push, output int kcap);
        send(mk(s), 3'(s.len()), ch, push, kcap);
    endtask

    string      pats [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
    logic [7:0] chs  [8] = '{"A", "B", "C", "D", "E", "F", "G", "H"};

    initial begin
        int k, k2, s0;
        bus.morse_one   = '0;
        bus.morse_two   = '0;
        bus.morse_three = '0;
        bus.morse_four  = '0;
        bus.morse_five  = '0;
        bus.morse_index = '0;
        bus.letter_done = 1'b0;
        bus.out_ready   = 1'b0;

        // Reset state
        tick(2);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_char", 32'(bus.out_char), 0);
        check("rst_count", 32'(bus.fifo_count), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        reset = 1'b1;
        tick(1);

        // Single letter U, streaming: visible for one cycle two edges later
        bus.out_ready = 1'b1;
        sendl("..-", "U", 1, k);
        check("u_not_yet", 32'(bus.out_valid), 0);
        tick(1);
        check("u_valid", 32'(bus.out_valid), 1);
        check("u_char", 32'(bus.out_char), 32'h55);
        tick(1);
        check("u_gone", 32'(bus.out_valid), 0);
        check("u_latency", 32'(last_char_cyc), 32'(k + 1));
        exp_q.push_back(8'h20);
        tick(12);
        check("u_space_gap", 32'(last_space_cyc - (k + 1)), GAP);

        // U then P five cycles apart, one space GAP edges after P
        s0 = space_cnt;
        sendl("..-", "U", 1, k);
        tick(4);
        sendl(".--.", "P", 1, k2);
        exp_q.push_back(8'h20);
        tick(2 * GAP + 6);
        check("p_latency", 32'(last_char_cyc), 32'(k2 + 1));
        check("p_space_gap", 32'(last_space_cyc - last_char_cyc), GAP);
        check("p_one_space", 32'(space_cnt - s0), 1);

        // Letter pending exactly when the gap expires: no space, timer re-arms
        s0 = space_cnt;
        sendl("..-", "U", 1, k);
        tick(GAP - 1);
        sendl("-", "T", 1, k2);
        exp_q.push_back(8'h20);
        tick(2 * GAP + 6);
        check("race_space_time", 32'(last_space_cyc), 32'(k2 + 1 + GAP));
        check("race_one_space", 32'(space_cnt - s0), 1);

        // Decode corner cases, back to back
        sendl("-----", "0", 1, k);
        send(mk(".x-"), 3'd3, "?", 1, k);
        send(mk("....."), 3'd6, "?", 1, k);
        send(mk("..."), 3'd5, "?", 1, k);
        send(mk(".") | 10'h3FC, 3'd1, "E", 1, k);
        sendl("--.-", "Q", 1, k);
        sendl("..---", "2", 1, k);
        exp_q.push_back(8'h20);
        tick(2 * GAP + 6);
        check("dec_drained", 32'(exp_q.size()), 0);

        // Fill with consumer stalled; index 0 ignored
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) sendl(pats[i], chs[i], 1, k);
        tick(1);
        check("fill3_count", 32'(bus.fifo_count), 3);
        send('0, 3'd0, 8'h00, 0, k);
        tick(1);
        check("idx0_count", 32'(bus.fifo_count), 3);
        for (int i = 3; i < 8; i++) sendl(pats[i], chs[i], 1, k);
        tick(1);
        check("full_count", 32'(bus.fifo_count), DEPTH);
        check("full_ovf", 32'(bus.overflow), 0);
        check("full_head", 32'(bus.out_char), 32'h41);

        // Push and pop on the same edge while full
        sendl("--..", "Z", 1, k);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        check("pp_count", 32'(bus.fifo_count), DEPTH);
        check("pp_ovf", 32'(bus.overflow), 0);

        // Push into a full FIFO without pop is dropped
        sendl("--.-", "Q", 0, k);
        tick(1);
        check("ovf_count", 32'(bus.fifo_count), DEPTH);
        check("ovf_set", 32'(bus.overflow), 1);
        tick(GAP + 3);
        check("ovf_space_drop", 32'(bus.fifo_count), DEPTH);
        check("ovf_sticky", 32'(bus.overflow), 1);

        bus.out_ready = 1'b1;
        tick(DEPTH + 2);
        check("drain_count", 32'(bus.fifo_count), 0);
        check("drain_sb", 32'(exp_q.size()), 0);

        // Asynchronous reset with entries queued and the timer armed
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) sendl(pats[i], chs[i], 1, k);
        tick(1);
        check("pre_rst_count", 32'(bus.fifo_count), 3);
        #3;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 0);
        check("arst_char", 32'(bus.out_char), 0);
        check("arst_count", 32'(bus.fifo_count), 0);
        check("arst_ovf", 32'(bus.overflow), 0);
        exp_q.delete();
        tick(2);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        s0 = space_cnt;
        tick(2 * GAP + 4);
        check("post_rst_no_space", 32'(space_cnt - s0), 0);
        check("post_rst_count", 32'(bus.fifo_count), 0);
        check("post_rst_valid", 32'(bus.out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/morse_to_letter.md
# morse_to_letter

Decodes each completed Morse letter from `button_to_morse` into an 8-bit ASCII character and buffers the results in a small FIFO for the display/compare stage downstream. Letters are captured on the `letter_done` pulse, looked up in a fixed table, and pushed into the FIFO. A word-gap timer inserts a space character when no new letter arrives for a set time after the last one. The downstream consumer drains the FIFO with a valid/ready handshake.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `GAP_TICKS`, 7: idle clock cycles after the last letter before a space is inserted; at least 1.
- `clock` in 1: system clock, same clock as `button_to_morse`.
- `reset` in 1: asynchronous, active-low reset.
- `morse_one`..`morse_five` in 2 each: symbol slots 1..5. Encoding: 00 empty, 01 dot, 10 dash, 11 invalid.
- `morse_index` in 3: number of symbols in the letter, 0..5.
- `letter_done` in 1: single-cycle pulse; the symbol slots and `morse_index` are valid in the same cycle.
- `out_ready` in 1: consumer accepts `out_char` this cycle.
- `out_char` out 8: ASCII character at the FIFO head.
- `out_valid` out 1: FIFO not empty.
- `fifo_count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky; set when a push is dropped.

## Operation
- Reset (`reset`=0): all outputs are 0, FIFO empty, capture register invalid, gap timer stopped and disarmed.
- Capture stage:
  - On a clock edge with `letter_done`=1 and `morse_index`≠0, latch the five slots and the index, and set `cap_valid`.
  - `letter_done` with `morse_index`=0 is ignored: no push, gap timer unaffected.
- Decode stage:
  - Use only slots 1..`morse_index`; higher slots are don't-care.
  - Table covers A–Z (uppercase ASCII) and 0–9.
  - Any of the following yields '?' (0x3F): no table match, a used slot equal to 00 or 11, or `morse_index`>5.
  - The decoded character is pushed on the edge after capture.
- Gap timer:
  - Every letter push clears the counter and arms the timer.
  - While armed, the counter increments each cycle.
  - When the count reaches GAP_TICKS, push 0x20 and disarm.
  - Only one space is pushed per gap; there is never a leading space after reset.
- Simultaneous events:
  - If a capture is pending (`cap_valid`) in the cycle the gap expires, the letter push wins; the space is dropped and the timer re-arms.
  - Pushes never coincide otherwise, since letters and spaces are mutually exclusive by construction.
- FIFO, show-ahead:
  - `out_char` = head entry whenever `out_valid`=1.
  - A pop occurs on an edge where `out_valid` and `out_ready` are both 1.
  - Push and pop in the same cycle are allowed at any occupancy, including full; occupancy is unchanged.
  - Push when full with no pop: the entry is dropped, `overflow` is set, and the pointers are unchanged.
  - Pointers wrap modulo DEPTH.
- `overflow` clears only on reset.
- Reset asserted mid-operation discards the pending capture, the FIFO contents and the timer state immediately (asynchronous).

## Timing
- `letter_done` high in cycle k:
  - edge k: capture
  - edge k+1: push
  - `out_valid`=1 from cycle k+2 if the FIFO was empty
- Latency from `letter_done` to `out_valid` is 2 cycles. Throughput is one letter per cycle.
- Space push occurs at edge k+1+GAP_TICKS after the last letter push at edge k+1, provided no new capture occurred.
- `fifo_count`, `out_valid` and `out_char` are registered or derived from registers; there is no combinational path from `out_ready` to any output.
- `out_ready` may be held high permanently; the block then streams.

## Structure
- Package `morse_pkg`:
  - symbol encodings SYM_EMPTY, SYM_DOT, SYM_DASH, SYM_BAD
  - ASCII constants CH_SPACE, CH_UNKNOWN
  - a 10-bit packed-pattern typedef
- Sub-module `morse_lut`: purely combinational; inputs are the 10-bit pattern and 3-bit index, output is the 8-bit ASCII code.
- The top level holds the capture register, gap timer and FIFO.

## Test plan
- Reset, then U (dot,dot,dash; index 3) with `out_ready`=1 -> `out_valid` for one cycle at k+2, `out_char`=0x55.
- U then P (dot,dash,dash,dot; index 4) 5 cycles apart, GAP_TICKS=7 -> sequence 0x55, 0x50, then 0x20 exactly GAP_TICKS cycles after the P push; only one space.
- Pattern dash,dash,dash,dash,dash (index 5) -> 0x30. Pattern with a used slot 11 -> 0x3F. `letter_done` with index 0 -> no push, `fifo_count` unchanged.
- `out_ready`=0 while 9 letters are sent, DEPTH=8 -> `fifo_count`=8, `overflow`=1; the drained order is the first 8 letters.
- FIFO full while push and pop occur in the same cycle -> `fifo_count` stays 8, `overflow` unchanged, new letter appears last.
- `reset` pulsed low with 3 entries queued and the timer armed -> all outputs 0 asynchronously; no space appears after release.
